// File: rtl/ysyx_22051013_axi_rd_arbiter_pkg.sv
// Shared widths, arbiter state encoding and master identifiers for the
// IFU/LSU AXI read-channel arbiter.
package ysyx_22051013_axi_rd_arbiter_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int RESP_W = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_AR   = 2'd1,
        ARB_R    = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } mst_e;

endpackage

// File: rtl/ysyx_22051013_axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick between IFU and LSU; purely combinational, the
// caller owns the last_grant register.
module ysyx_22051013_rr_arb2
    import ysyx_22051013_axi_rd_arbiter_pkg::*;
(
    input  logic ifu_req,
    input  logic lsu_req,
    input  mst_e last_grant,
    output logic gnt_vld,
    output mst_e gnt
);

    always_comb begin
        gnt_vld = ifu_req | lsu_req;
        gnt     = MST_IFU;
        if (ifu_req && lsu_req) begin
            // On a tie the master that did not win last time goes first.
            if (last_grant == MST_LSU) begin
                gnt = MST_IFU;
            end else begin
                gnt = MST_LSU;
            end
        end else if (lsu_req) begin
            gnt = MST_LSU;
        end
    end

endmodule

// File: rtl/ysyx_22051013_axi_rd_arbiter.sv
// Shares one AXI read slave between IFU and LSU, one transaction at a time:
// IDLE arbitrates, AR forwards the address phase, R forwards the data beat.
module ysyx_22051013_axi_rd_arbiter
    import ysyx_22051013_axi_rd_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_ar_addr,
    input  logic              ifu_ar_valid,
    output logic              ifu_ar_ready,
    output logic [DATA_W-1:0] ifu_r_data,
    output logic [RESP_W-1:0] ifu_r_resp,
    output logic              ifu_r_valid,
    input  logic              ifu_r_ready,

    input  logic [ADDR_W-1:0] lsu_ar_addr,
    input  logic              lsu_ar_valid,
    output logic              lsu_ar_ready,
    output logic [DATA_W-1:0] lsu_r_data,
    output logic [RESP_W-1:0] lsu_r_resp,
    output logic              lsu_r_valid,
    input  logic              lsu_r_ready,

    output logic [ADDR_W-1:0] mem_ar_addr,
    output logic              mem_ar_valid,
    input  logic              mem_ar_ready,
    input  logic [DATA_W-1:0] mem_r_data,
    input  logic [RESP_W-1:0] mem_r_resp,
    input  logic              mem_r_valid,
    output logic              mem_r_ready
);

    arb_state_e state_q, state_d;
    mst_e       grant_q, grant_d;
    mst_e       last_grant_q, last_grant_d;

    logic       pick_vld;
    mst_e       pick;

    logic              sel_ar_valid;
    logic [ADDR_W-1:0] sel_ar_addr;
    logic              sel_r_ready;

    ysyx_22051013_rr_arb2 u_rr_arb2 (
        .ifu_req    (ifu_ar_valid),
        .lsu_req    (lsu_ar_valid),
        .last_grant (last_grant_q),
        .gnt_vld    (pick_vld),
        .gnt        (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= MST_IFU;
            last_grant_q <= MST_LSU;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        sel_ar_valid = (grant_q == MST_LSU) ? lsu_ar_valid : ifu_ar_valid;
        sel_ar_addr  = (grant_q == MST_LSU) ? lsu_ar_addr  : ifu_ar_addr;
        sel_r_ready  = (grant_q == MST_LSU) ? lsu_r_ready  : ifu_r_ready;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;

        ifu_ar_ready = 1'b0;
        ifu_r_valid  = 1'b0;
        ifu_r_data   = '0;
        ifu_r_resp   = '0;
        lsu_ar_ready = 1'b0;
        lsu_r_valid  = 1'b0;
        lsu_r_data   = '0;
        lsu_r_resp   = '0;
        mem_ar_addr  = '0;
        mem_ar_valid = 1'b0;
        mem_r_ready  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    state_d      = ARB_AR;
                end
            end
            ARB_AR: begin
                // A master withdrawing its request here just idles the slave.
                mem_ar_addr  = sel_ar_addr;
                mem_ar_valid = sel_ar_valid;
                if (grant_q == MST_LSU) begin
                    lsu_ar_ready = mem_ar_ready;
                end else begin
                    ifu_ar_ready = mem_ar_ready;
                end
                if (sel_ar_valid && mem_ar_ready) begin
                    state_d = ARB_R;
                end
            end
            ARB_R: begin
                mem_r_ready = sel_r_ready;
                if (grant_q == MST_LSU) begin
                    lsu_r_valid = mem_r_valid;
                    lsu_r_data  = mem_r_data;
                    lsu_r_resp  = mem_r_resp;
                end else begin
                    ifu_r_valid = mem_r_valid;
                    ifu_r_data  = mem_r_data;
                    ifu_r_resp  = mem_r_resp;
                end
                if (mem_r_valid && sel_r_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule
